// File: rtl/bram2dac.sv
// bram2dac: BRAM playback engine feeding two 16-bit AXI4-Stream channels.
// A trigger edge starts a pass over the buffer. Reads are paced by a
// credit check against a small prefetch FIFO, so output runs at one beat
// per cycle when both consumers are ready and stalls cleanly otherwise.
module bram2dac #(
  parameter logic [31:0] MAXADDR    = 32'd65536,
  parameter int          BRAM_LAT   = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Play_trig,
  input  logic        Loop_en,
  input  logic [31:0] Play_len,
  output logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        BRAM_EN,
  output logic        BRAM_WE,
  output logic [15:0] M00_axis_tdata,
  output logic        M00_axis_tvalid,
  input  logic        M00_axis_tready,
  output logic [15:0] M01_axis_tdata,
  output logic        M01_axis_tvalid,
  input  logic        M01_axis_tready,
  output logic        Busy,
  output logic        Done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_nxt;

  // Trigger synchroniser / edge detector
  logic r1, r2, r3;
  logic start;

  // Playback control
  logic [31:0] len;
  logic        issue;
  logic        last_rd;
  logic        drain_done;

  // In-flight read tags and prefetch FIFO
  logic [BRAM_LAT-1:0] vld_p;
  logic [CNT_W-1:0]    inflight_cnt;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [CNT_W-1:0]    credit;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [31:0]         fifo_mem [FIFO_DEPTH];
  logic                push, pop, tvalid;

  // Round the requested length down to whole words; saturate empty or
  // oversized requests to the full buffer.
  function automatic logic [31:0] clamp_len(input logic [31:0] plen);
    logic [31:0] l;
    l = {plen[31:2], 2'b00};
    if ((l == 32'd0) || (l > MAXADDR)) begin
      return MAXADDR;
    end
    return l;
  endfunction

  // Circular FIFO pointer advance for any depth, not only powers of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign BRAM_WE = 1'b0;
  assign start   = r2 & ~r3 & ~Busy;
  assign last_rd = issue && (addr == (len - 32'd4));
  assign credit  = fifo_cnt + inflight_cnt;
  assign push    = vld_p[BRAM_LAT-1];
  assign tvalid  = (fifo_cnt != '0);
  assign pop     = tvalid && M00_axis_tready && M01_axis_tready;

  assign M00_axis_tvalid = tvalid;
  assign M01_axis_tvalid = tvalid;
  assign M00_axis_tdata  = tvalid ? fifo_mem[rd_ptr][31:16] : 16'h0000;
  assign M01_axis_tdata  = tvalid ? fifo_mem[rd_ptr][15:0]  : 16'h0000;

  // Trigger input: three-flop chain, rising edge seen between r2 and r3
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
      r3 <= 1'b0;
    end else begin
      r1 <= Play_trig;
      r2 <= r1;
      r3 <= r2;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_rd && !Loop_en) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_nxt = start ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: read issue gated by FIFO credit, status flags
  always_comb begin
    issue      = (state == RUN) && (credit < DEPTH_C);
    drain_done = (state == DRAIN) && (inflight_cnt == '0) && (fifo_cnt == '0);
    BRAM_EN    = issue;
    Done       = drain_done;
    Busy       = (state == RUN) || ((state == DRAIN) && !drain_done);
  end

  // Address generator and pass length; wraps to 0 on a looped last read
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= 32'd0;
    end else if (start) begin
      addr <= 32'd0;
    end else if (issue) begin
      addr <= (last_rd && Loop_en) ? 32'd0 : addr + 32'd4;
    end
  end

  // Pass length captured at the start edge
  always_ff @(posedge clk) begin
    if (start) begin
      len <= clamp_len(Play_len);
    end
  end

  // ---- stage p0..pLAT-1: read tags travel alongside BRAM latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p        <= '0;
      inflight_cnt <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < BRAM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
      inflight_cnt <= inflight_cnt + CNT_W'(issue) - CNT_W'(push);
    end
  end

  // ---- FIFO stage: capture returning word when its tag emerges ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: doc/bram2dac.md
# bram2dac

Playback engine, the transmit-side counterpart of the ADC capture path. On a trigger, it reads 32-bit words from a BRAM port and streams them as two 16-bit AXI4-Stream master channels toward the RF-DAC. It supports single-shot and looped playback. A prefetch FIFO hides BRAM read latency and keeps full throughput under `tready` backpressure. The BRAM word packing is identical to the capture path: upper half is channel 00, lower half is channel 01.

## Interface
- `MAXADDR`, default 32'd65536: buffer size in bytes; also the playback length used when `Play_len` is clamped.
- `BRAM_LAT`, default 2: BRAM read latency in cycles, from address/enable to `data_in` valid.
- `FIFO_DEPTH`, default 4: prefetch FIFO depth; must be ≥ `BRAM_LAT`+2.
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset.
- `Play_trig`  in  1: asynchronous level; a rising edge starts playback.
- `Loop_en`  in  1: level; if high at the end of a pass, playback wraps to 0.
- `Play_len`  in  32: pass length in bytes, sampled at the trigger edge; bits [1:0] are ignored.
- `addr`  out  32: BRAM byte address; steps by 4.
- `data_in`  in  32: BRAM read data.
- `BRAM_EN`  out  1: BRAM read enable; high only on cycles that issue a read.
- `BRAM_WE`  out  1: tied to 0.
- `M00_axis_tdata`  out  16: equals `data_in[31:16]` of the word at the FIFO head.
- `M00_axis_tvalid`  out  1: channel 00 valid.
- `M00_axis_tready`  in  1: channel 00 ready.
- `M01_axis_tdata`  out  16: equals `data_in[15:0]` of the word at the FIFO head.
- `M01_axis_tvalid`  out  1: channel 01 valid; always equal to `M00_axis_tvalid`.
- `M01_axis_tready`  in  1: channel 01 ready.
- `Busy`  out  1: high in RUN and DRAIN.
- `Done`  out  1: one-cycle pulse when a non-looped playback completes.

## Operation
- **Trigger conditioning:**
  - `Play_trig` passes through a 3-flop chain (r1, r2, r3).
  - A start is detected when r2=1 and r3=0.
  - A start is ignored while `Busy` is high.
- **Length latching:** at start, latch `len = {Play_len[31:2], 2'b00}`. If `len == 0` or `len > MAXADDR`, use `len = MAXADDR`.
- **State machine:**
  - IDLE → RUN on start; `addr` is set to 0.
  - **RUN:**
    - Issue a read (`BRAM_EN=1` with the current `addr`) only when FIFO occupancy plus in-flight reads is less than `FIFO_DEPTH`.
    - After each issued read, `addr` increments by 4.
    - When the issued address equals `len`-4:
      - If `Loop_en` is high on that cycle, the next `addr` is 0 and the state stays RUN.
      - Otherwise, go to DRAIN.
  - **DRAIN:** no new reads are issued. When in-flight reads reach 0 and the FIFO is empty, pulse `Done` and go to IDLE.
- **In-flight tracking:** a shift register of depth `BRAM_LAT` tags reads in flight. `data_in` is pushed into the FIFO when the tag emerges.
- **Output handshake:**
  - Both channels share one `tvalid`.
  - A beat transfers only when `tvalid && M00_axis_tready && M01_axis_tready`; the beat is then popped from the FIFO.
  - Once `tvalid` is asserted, `tdata` and `tvalid` are held stable until the transfer. AXI rules apply: no `tready` dependence on `tvalid`.
- **Ordering:** words are emitted strictly in address order with no loss or duplication. On a loop wrap, the last word of a pass is followed directly by the word at address 0.
- **Reset behaviour:**
  - `rst` forces IDLE.
  - FIFO is emptied and in-flight tags are cleared.
  - `addr`=0; `BRAM_EN`=0; `BRAM_WE`=0; both `tvalid`=0; `tdata`=0; `Busy`=0; `Done`=0.
  - Trigger flops are cleared to 0.
  - Reset mid-run discards all pending data. BRAM returns after reset are ignored.

## Timing
- With a `Play_trig` rising edge sampled at cycle T:
  - r2 is high at T+2 and the start is detected at T+2.
  - RUN is entered, with the first read issued (`addr`=0, `BRAM_EN`=1), at T+3.
- First `tvalid` asserts at T+3+`BRAM_LAT`+1: FIFO write, then registered output.
- Throughput with both `tready` held high is 1 beat per cycle with no bubbles, including across loop wraps.
- Under backpressure, reads stall within one cycle of the FIFO credit reaching `FIFO_DEPTH`. The FIFO never overflows.
- `Done` asserts exactly one cycle after the last beat's handshake. `Busy` deasserts on the same cycle as `Done`.

## Test plan
- **Single pass:** BRAM[i]=`{16'h1000+i, 16'h2000+i}`, `Play_len`=16, `Loop_en`=0, both `tready` high. Expect 4 beats: M00 = 1000..1003, M01 = 2000..2003, consecutive cycles; first `tvalid` at T+3+`BRAM_LAT`+1; then one `Done` pulse.
- **Backpressure:** `Play_len`=256, both `tready` toggled pseudo-randomly and independently. Expect 64 beats in order with no duplicates; `tdata` stable while stalled; FIFO never overflows.
- **Loop:** `Play_len`=8, `Loop_en`=1. Expect the word sequence 0,1,0,1,… with no bubble at the wrap. Drop `Loop_en` mid-pass: the current pass finishes on word 1, then `Done` fires.
- **Length clamp:** `Play_len`=0 and `Play_len`=`MAXADDR`+64. Both play exactly `MAXADDR`/4 beats; the last address issued is `MAXADDR`-4.
- **Retrigger and reset:** a second `Play_trig` edge during RUN is ignored (beat count unchanged). Assert `rst` mid-run with `tready` low: the next cycle shows `tvalid`=0, `Busy`=0, `addr`=0. A new trigger then plays from word 0.
